// File: rtl/fp2int_rr_sched_pkg.sv
// rtl/fp2int_rr_sched_pkg.sv - shared parameters, FSM encoding and helpers
package fp2int_rr_sched_pkg;

  localparam int NUM_REQ_D   = 4;
  localparam int DWIDTH_D    = 16;
  localparam int BURST_LEN_D = 4;
  localparam int ID_W_D      = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  function automatic logic [2:0] wrap_inc(input logic [2:0] id, input int n);
    return (int'(id) == n - 1) ? 3'd0 : id + 3'd1;
  endfunction

endpackage

// File: rtl/float_to_int_fp16.sv
// rtl/float_to_int_fp16.sv - fp16 to int16 conversion, truncating toward zero
module float_to_int_fp16 (
  input  logic [15:0] fp_in,
  output logic [15:0] int_out,
  output logic        sat
);

  logic [4:0]  exp_f;
  logic [15:0] sig;
  logic [15:0] mag;

  assign exp_f = fp_in[14:10];
  assign sig   = {5'd0, 1'b1, fp_in[9:0]};

  // Binary point of sig sits at bit 10; unbiased exponent shifts it (bias 15).
  always_comb begin
    mag = '0;
    if (exp_f >= 5'd25) begin
      mag = sig << (exp_f - 5'd25);
    end else if (exp_f >= 5'd15) begin
      mag = sig >> (5'd25 - exp_f);
    end
    sat     = (exp_f == 5'd31);
    int_out = sat ? 16'hFFFF : (fp_in[15] ? (16'd0 - mag) : mag);
  end

endmodule

// File: rtl/fp2int_rr_arbiter.sv
// rtl/fp2int_rr_arbiter.sv - round-robin pick of first valid requester at or after rr_ptr
module fp2int_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [ID_W-1:0]    rr_ptr,
  input  logic [NUM_REQ-1:0] valid,
  output logic [NUM_REQ-1:0] grant,
  output logic [ID_W-1:0]    grant_id
);

  int idx;

  // Walk from lowest to highest priority so the last hit is the winner.
  always_comb begin
    grant    = '0;
    grant_id = '0;
    idx      = 0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQ) idx = idx - NUM_REQ;
      if (valid[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        grant_id   = ID_W'(idx);
      end
    end
  end

endmodule

// File: rtl/fp2int_rr_sched.sv
// rtl/fp2int_rr_sched.sv - shares one fp16->int16 converter among requesters, RR with burst lock
module fp2int_rr_sched
  import fp2int_rr_sched_pkg::*;
#(
  parameter int NUM_REQ   = NUM_REQ_D,
  parameter int DWIDTH    = DWIDTH_D,
  parameter int BURST_LEN = BURST_LEN_D,
  parameter int ID_W      = ID_W_D
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DWIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic                      out_valid,
  output logic [DWIDTH-1:0]         out_data,
  output logic [ID_W-1:0]           out_id,
  output logic                      out_sat,
  input  logic                      out_ready,
  output logic                      busy
);

  localparam int CNT_W = $clog2(BURST_LEN + 1);

  state_e             state, state_nxt;
  logic [ID_W-1:0]    owner, owner_nxt, rr_ptr, rr_ptr_nxt, sel_id, grant_id;
  logic [CNT_W-1:0]   burst_cnt, burst_cnt_nxt;
  logic [NUM_REQ-1:0] grant;
  logic               s1_valid, s2_valid, adv, s1_load, accept, acc_last;
  logic [DWIDTH-1:0]  s1_data, acc_data, conv_data;
  logic [ID_W-1:0]    s1_id;
  logic               conv_sat;

  fp2int_rr_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) u_arb (
    .rr_ptr   (rr_ptr),
    .valid    (req_valid),
    .grant    (grant),
    .grant_id (grant_id)
  );

  float_to_int_fp16 u_conv (
    .fp_in   (s1_data),
    .int_out (conv_data),
    .sat     (conv_sat)
  );

  assign adv      = !s2_valid || out_ready;
  assign s1_load  = !s1_valid || adv;
  assign sel_id   = (state == BURST) ? owner : grant_id;
  assign accept   = |(req_ready & req_valid);
  assign acc_last = req_last[sel_id];
  assign acc_data = req_data[sel_id*DWIDTH +: DWIDTH];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state     <= IDLE;
      owner     <= '0;
      rr_ptr    <= '0;
      burst_cnt <= '0;
    end else begin
      state     <= state_nxt;
      owner     <= owner_nxt;
      rr_ptr    <= rr_ptr_nxt;
      burst_cnt <= burst_cnt_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    owner_nxt     = owner;
    rr_ptr_nxt    = rr_ptr;
    burst_cnt_nxt = burst_cnt;
    case (state)
      IDLE: begin
        if (accept) begin
          if (acc_last || BURST_LEN == 1) begin
            rr_ptr_nxt = ID_W'(wrap_inc(3'(grant_id), NUM_REQ));
          end else begin
            state_nxt     = BURST;
            owner_nxt     = grant_id;
            burst_cnt_nxt = CNT_W'(1);
          end
        end
      end
      BURST: begin
        // Dropping valid only ends the burst when the owner could actually have been taken.
        if ((accept && (acc_last || burst_cnt == CNT_W'(BURST_LEN - 1))) ||
            (!accept && s1_load && !req_valid[owner])) begin
          state_nxt     = IDLE;
          rr_ptr_nxt    = ID_W'(wrap_inc(3'(owner), NUM_REQ));
          burst_cnt_nxt = '0;
        end else if (accept) begin
          burst_cnt_nxt = burst_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    req_ready = '0;
    if (resetn && s1_load) begin
      if (state == BURST) req_ready[owner] = 1'b1;
      else                req_ready = grant;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_id    <= '0;
      s2_valid <= 1'b0;
      out_data <= '0;
      out_id   <= '0;
      out_sat  <= 1'b0;
    end else begin
      if (adv) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          out_data <= conv_data;
          out_id   <= s1_id;
          out_sat  <= conv_sat;
        end
      end
      if (s1_load) begin
        s1_valid <= accept;
        if (accept) begin
          s1_data <= acc_data;
          s1_id   <= sel_id;
        end
      end
    end
  end

  assign out_valid = s2_valid;
  assign busy      = s1_valid || s2_valid || (state == BURST);

endmodule
